// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
//   Parses ASCII commands arriving from UART_RX and drives a registered VGA
//   pattern select plus a one-byte reply toward UART_TX.
//     "P<d>\r" (d = '0'..'7') stages d as the pending pattern, replies 'K'.
//     "?\r"                   replies the ASCII digit of the applied pattern.
//     Anything malformed      replies 'E' and pulses o_Cmd_Err.
//   The staged pattern is only applied on a falling edge of i_VSync, so the
//   visible pattern never changes in the middle of a frame.
//
// Ports
//   i_Clk         pixel/UART clock
//   i_Rst_L       asynchronous active-low reset
//   i_RX_DV       one-cycle strobe, i_RX_Byte valid
//   i_RX_Byte     received byte
//   i_TX_Active   UART_TX busy shifting a byte
//   i_VSync       VGA vertical sync (active low); falling edge = frame boundary
//   o_Pattern_Sel applied pattern select
//   o_TX_DV       one-cycle strobe to UART_TX
//   o_TX_Byte     reply byte, held until the next reply
//   o_Cmd_Err     one-cycle pulse on a rejected, dropped or timed-out command
// -----------------------------------------------------------------------------
module uart_cmd_decoder #(
  parameter int g_Timeout_Clks = 43400
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_VSync,
  output logic [2:0] o_Pattern_Sel,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic       o_Cmd_Err
);

  localparam int CW = $clog2(g_Timeout_Clks);
  localparam logic [CW-1:0] TMO_LAST = CW'(g_Timeout_Clks - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GOT_P      = 3'd1;
  localparam logic [2:0] ST_GOT_DIGIT  = 3'd2;
  localparam logic [2:0] ST_GOT_Q      = 3'd3;
  localparam logic [2:0] ST_REPLY_WAIT = 3'd4;

  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;

  logic [2:0]    state_r, state_s;
  logic [2:0]    temp_r, temp_s;
  logic [2:0]    pending_r, pending_s;
  logic [7:0]    reply_r, reply_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          err_s, tx_dv_s;
  logic [7:0]    tx_byte_s;
  logic          vsync_d_r;
  logic          is_digit_s, in_cmd_s, frame_edge_s;

  assign is_digit_s   = (i_RX_Byte >= 8'h30) && (i_RX_Byte <= 8'h37);
  assign in_cmd_s     = (state_r == ST_GOT_P) || (state_r == ST_GOT_DIGIT) ||
                        (state_r == ST_GOT_Q);
  assign frame_edge_s = vsync_d_r && !i_VSync;

  // Command parser next-state, reply selection and timeout counter.
  always_comb begin
    state_s   = state_r;
    temp_s    = temp_r;
    pending_s = pending_r;
    reply_s   = reply_r;
    cnt_s     = cnt_r;
    err_s     = 1'b0;
    tx_dv_s   = 1'b0;
    tx_byte_s = o_TX_Byte;

    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (i_RX_DV) begin
          case (i_RX_Byte)
            ASCII_P:            state_s = ST_GOT_P;
            ASCII_Q:            state_s = ST_GOT_Q;
            ASCII_CR, ASCII_LF: state_s = ST_IDLE;
            default: begin
              state_s = ST_REPLY_WAIT;
              reply_s = ASCII_E;
              err_s   = 1'b1;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_GOT_P: begin
        if (i_RX_DV && is_digit_s) begin
          temp_s  = i_RX_Byte[2:0];
          state_s = ST_GOT_DIGIT;
        end else if (i_RX_DV) begin
          state_s = ST_REPLY_WAIT;
          reply_s = ASCII_E;
          err_s   = 1'b1;
        end else begin
          state_s = ST_GOT_P;
        end
      end

      ST_GOT_DIGIT: begin
        if (i_RX_DV && (i_RX_Byte == ASCII_CR)) begin
          pending_s = temp_r;
          state_s   = ST_REPLY_WAIT;
          reply_s   = ASCII_K;
        end else if (i_RX_DV) begin
          state_s = ST_REPLY_WAIT;
          reply_s = ASCII_E;
          err_s   = 1'b1;
        end else begin
          state_s = ST_GOT_DIGIT;
        end
      end

      ST_GOT_Q: begin
        if (i_RX_DV && (i_RX_Byte == ASCII_CR)) begin
          // Query reports the applied select, never the staged one.
          state_s = ST_REPLY_WAIT;
          reply_s = {5'b00110, o_Pattern_Sel};
        end else if (i_RX_DV) begin
          state_s = ST_REPLY_WAIT;
          reply_s = ASCII_E;
          err_s   = 1'b1;
        end else begin
          state_s = ST_GOT_Q;
        end
      end

      ST_REPLY_WAIT: begin
        cnt_s = CNT_ZERO;
        // Bytes arriving while a reply is outstanding are dropped.
        if (i_RX_DV) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
        if (!i_TX_Active) begin
          tx_byte_s = reply_r;
          tx_dv_s   = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_REPLY_WAIT;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    // Inter-byte timeout: any accepted byte restarts the count; otherwise the
    // count advances until the limit aborts the command silently.
    if (in_cmd_s && i_RX_DV) begin
      cnt_s = CNT_ZERO;
    end else if (in_cmd_s && (cnt_r == TMO_LAST)) begin
      cnt_s   = CNT_ZERO;
      state_s = ST_IDLE;
      err_s   = 1'b1;
    end else if (in_cmd_s) begin
      cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = cnt_s;
    end
  end

  // Parser state and registered reply/error outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r   <= ST_IDLE;
      temp_r    <= 3'd0;
      pending_r <= 3'd0;
      reply_r   <= 8'h00;
      cnt_r     <= CNT_ZERO;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= 8'h00;
      o_Cmd_Err <= 1'b0;
    end else begin
      state_r   <= state_s;
      temp_r    <= temp_s;
      pending_r <= pending_s;
      reply_r   <= reply_s;
      cnt_r     <= cnt_s;
      o_TX_DV   <= tx_dv_s;
      o_TX_Byte <= tx_byte_s;
      o_Cmd_Err <= err_s;
    end
  end

  // Frame-boundary apply: a staging CR in the edge cycle still sees the old
  // pending value here, so the new one waits for the following frame.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vsync_d_r     <= 1'b1;
      o_Pattern_Sel <= 3'd0;
    end else begin
      vsync_d_r <= i_VSync;
      if (frame_edge_s) begin
        o_Pattern_Sel <= pending_r;
      end else begin
        o_Pattern_Sel <= o_Pattern_Sel;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
//   Directed, table-driven bench for uart_cmd_decoder plus hand-written
//   sequences for frame-edge latency, timeout, TX back-pressure and reset.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_active;
  logic       vsync;
  logic [2:0] pattern_sel;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       cmd_err;

  int checks   = 0;
  int failures = 0;
  int tx_cnt   = 0;
  int err_cnt  = 0;

  uart_cmd_decoder #(.g_Timeout_Clks(T)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_RX_DV      (rx_dv),
    .i_RX_Byte    (rx_byte),
    .i_TX_Active  (tx_active),
    .i_VSync      (vsync),
    .o_Pattern_Sel(pattern_sel),
    .o_TX_DV      (tx_dv),
    .o_TX_Byte    (tx_byte),
    .o_Cmd_Err    (cmd_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (tx_dv)   tx_cnt  <= tx_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    int         exp_tx;
    logic [7:0] exp_byte;
    int         exp_err;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    @(posedge clk); #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
    repeat (idle) @(posedge clk);
  endtask

  task automatic frame_edge();
    @(posedge clk); #1;
    vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic send_cmd3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 2);
    send_byte(b, 2);
    send_byte(c, 2);
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
  endtask

  int tx_base, err_base;
  logic [2:0] prev_sel;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h50, 8'h35, 8'h0D, 3, 1, 8'h4B, 0, 3'd5}; // P5\r
    vecs[1]  = '{8'h50, 8'h39, 8'h0D, 3, 1, 8'h45, 1, 3'd5}; // P9\r
    vecs[2]  = '{8'h50, 8'h33, 8'h0D, 3, 1, 8'h4B, 0, 3'd3}; // P3\r
    vecs[3]  = '{8'h3F, 8'h0D, 8'h00, 2, 1, 8'h33, 0, 3'd3}; // ?\r
    vecs[4]  = '{8'h58, 8'h00, 8'h00, 1, 1, 8'h45, 1, 3'd3}; // X
    vecs[5]  = '{8'h0A, 8'h00, 8'h00, 1, 0, 8'h45, 0, 3'd3}; // LF
    vecs[6]  = '{8'h50, 8'h37, 8'h0D, 3, 1, 8'h4B, 0, 3'd7}; // P7\r
    vecs[7]  = '{8'h50, 8'h30, 8'h0D, 3, 1, 8'h4B, 0, 3'd0}; // P0\r
    vecs[8]  = '{8'h50, 8'h2F, 8'h0D, 3, 1, 8'h45, 1, 3'd0}; // P/\r
    vecs[9]  = '{8'h50, 8'h38, 8'h0D, 3, 1, 8'h45, 1, 3'd0}; // P8\r
    vecs[10] = '{8'h3F, 8'h58, 8'h00, 2, 1, 8'h45, 1, 3'd0}; // ?X
    vecs[11] = '{8'h50, 8'h34, 8'h58, 3, 1, 8'h45, 1, 3'd0}; // P4X

    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; tx_active = 1'b0; vsync = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'(pattern_sel), 32'd0);
    check("rst_tx_dv", 32'(tx_dv), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'h00);
    check("rst_err", 32'(cmd_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven commands, each followed by one frame edge.
    prev_sel = 3'd0;
    for (int i = 0; i < 12; i++) begin
      tx_base  = tx_cnt;
      err_base = err_cnt;
      if (vecs[i].n == 3)      send_cmd3(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      else if (vecs[i].n == 2) begin send_byte(vecs[i].b0, 2); send_byte(vecs[i].b1, 6); @(negedge clk); #1; end
      else                     begin send_byte(vecs[i].b0, 6); @(negedge clk); #1; end
      check($sformatf("v%0d_sel_pre_edge", i), 32'(pattern_sel), 32'(prev_sel));
      frame_edge();
      check($sformatf("v%0d_tx_count", i), 32'(tx_cnt - tx_base), 32'(vecs[i].exp_tx));
      check($sformatf("v%0d_tx_byte", i), 32'(tx_byte), 32'(vecs[i].exp_byte));
      check($sformatf("v%0d_err_count", i), 32'(err_cnt - err_base), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_sel", i), 32'(pattern_sel), 32'(vecs[i].exp_sel));
      prev_sel = vecs[i].exp_sel;
    end

    // Query before edge reports applied value; edge latency is exactly one cycle.
    send_cmd3(8'h50, 8'h36, 8'h0D);
    check("stage6_reply", 32'(tx_byte), 32'h4B);
    send_byte(8'h3F, 2); send_byte(8'h0D, 6);
    check("query_not_pending", 32'(tx_byte), 32'h30);
    @(posedge clk); #1 vsync = 1'b0;
    @(negedge clk); #1;
    check("edge_cycle_k_old", 32'(pattern_sel), 32'd0);
    @(negedge clk); #1;
    check("edge_cycle_k1_new", 32'(pattern_sel), 32'd6);
    @(posedge clk); #1 vsync = 1'b1;
    repeat (2) @(posedge clk);

    // Staging CR coincident with the edge cycle applies the old pending value.
    send_cmd3(8'h50, 8'h31, 8'h0D);
    send_byte(8'h50, 2); send_byte(8'h32, 2);
    @(posedge clk); #1;
    rx_dv = 1'b1; rx_byte = 8'h0D; vsync = 1'b0;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    repeat (2) @(posedge clk);
    #1 vsync = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check("coincident_edge_old", 32'(pattern_sel), 32'd1);
    frame_edge();
    check("coincident_next_frame", 32'(pattern_sel), 32'd2);
    send_cmd3(8'h50, 8'h34, 8'h0D);
    send_cmd3(8'h50, 8'h35, 8'h0D);
    frame_edge();
    check("last_p_wins", 32'(pattern_sel), 32'd5);

    // Timeout after 'P' with no further bytes.
    tx_base = tx_cnt; err_base = err_cnt;
    send_byte(8'h50, 0);
    repeat (T) @(negedge clk);
    #1 check("timeout_not_early", 32'(err_cnt - err_base), 32'd0);
    @(negedge clk); #1;
    check("timeout_err", 32'(err_cnt - err_base), 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("timeout_no_tx", 32'(tx_cnt - tx_base), 32'd0);
    check("timeout_single_err", 32'(err_cnt - err_base), 32'd1);
    tx_base = tx_cnt;
    send_cmd3(8'h50, 8'h32, 8'h0D);
    check("after_timeout_tx", 32'(tx_cnt - tx_base), 32'd1);
    check("after_timeout_k", 32'(tx_byte), 32'h4B);

    // Reply held off by a busy transmitter; a byte during the wait is dropped.
    tx_active = 1'b1;
    tx_base = tx_cnt; err_base = err_cnt;
    send_byte(8'h50, 2); send_byte(8'h33, 2); send_byte(8'h0D, 2);
    send_byte(8'h5A, 2);
    repeat (500) @(posedge clk);
    @(negedge clk); #1;
    check("busy_no_tx", 32'(tx_cnt - tx_base), 32'd0);
    check("busy_drop_err", 32'(err_cnt - err_base), 32'd1);
    @(posedge clk); #1 tx_active = 1'b0;
    @(negedge clk); #1;
    check("busy_fall_cycle", 32'(tx_cnt - tx_base), 32'd0);
    @(negedge clk); #1;
    check("busy_tx_after_fall", 32'(tx_cnt - tx_base), 32'd1);
    check("busy_reply_k", 32'(tx_byte), 32'h4B);
    frame_edge();
    check("busy_sel3", 32'(pattern_sel), 32'd3);

    // Asynchronous reset between 'P' and the digit.
    tx_base = tx_cnt;
    send_byte(8'h50, 0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_sel", 32'(pattern_sel), 32'd0);
    check("mid_rst_tx_dv", 32'(tx_dv), 32'd0);
    check("mid_rst_tx_byte", 32'(tx_byte), 32'h00);
    check("mid_rst_err", 32'(cmd_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    err_base = err_cnt;
    send_byte(8'h35, 6);
    @(negedge clk); #1;
    check("post_rst_from_idle_err", 32'(err_cnt - err_base), 32'd1);
    check("post_rst_reply_e", 32'(tx_byte), 32'h45);
    check("post_rst_tx_count", 32'(tx_cnt - tx_base), 32'd1);
    frame_edge();
    check("post_rst_sel_edge1", 32'(pattern_sel), 32'd0);
    frame_edge();
    check("post_rst_sel_edge2", 32'(pattern_sel), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
